// File: rtl/fw_drop_filter.sv
// rtl/fw_drop_filter.sv - store-and-forward stage that discards firewall-marked packets
// Whole packets are buffered and released only once their EOP proves them unmarked.
module fw_drop_filter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 9,
  parameter logic [CTRL_WIDTH-1:0] DROP_CTRL = CTRL_WIDTH'(8'h54)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           pass_cnt,
  output logic [31:0]           drop_cnt,
  output logic [31:0]           oversize_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LEN_MAX = PW'(DEPTH - 2);
  localparam logic [PW-1:0] ONE_P   = PW'(1);
  localparam logic [PW-1:0] TWO_P   = PW'(2);

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_BODY = 2'd1;
  localparam logic [1:0] S_SINK = 2'd2;

  logic [WW-1:0]         r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_pkt_start;
  logic [PW-1:0]         r_commit_ptr;
  logic [PW-1:0]         r_rd_limit;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_pkt_len;
  logic [1:0]            r_state;
  logic                  r_mark;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CTRL_WIDTH-1:0] r_out_ctrl;
  logic                  r_out_wr;
  logic [31:0]           r_pass_cnt;
  logic [31:0]           r_drop_cnt;
  logic [31:0]           r_oversize_cnt;

  logic [PW-1:0] w_used;
  logic [PW-1:0] w_free;
  logic          w_ctrl_zero;
  logic          w_ctrl_drop;
  logic          w_ctrl_other;
  logic          w_store;
  logic          w_commit;
  logic          w_discard;
  logic          w_overflow;
  logic          w_sink_exit;
  logic          w_mark_set;
  logic          w_rd;
  logic [1:0]    w_next_state;

  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_free = DEPTH_P - w_used;

  // The free>=2 threshold leaves room for the one word upstream may send after in_rdy falls.
  assign in_rdy = (w_free >= TWO_P) || (r_state == S_SINK);

  assign w_ctrl_zero  = (in_ctrl == '0);
  assign w_ctrl_drop  = (in_ctrl == DROP_CTRL);
  assign w_ctrl_other = !w_ctrl_zero && !w_ctrl_drop;

  always_comb begin
    w_store      = 1'b0;
    w_commit     = 1'b0;
    w_discard    = 1'b0;
    w_overflow   = 1'b0;
    w_sink_exit  = 1'b0;
    w_mark_set   = 1'b0;
    w_next_state = r_state;
    if (in_wr) begin
      case (r_state)
        S_HDR, S_BODY: begin
          if ((r_state == S_BODY) && w_ctrl_other) begin
            w_next_state = S_HDR;
            if (r_mark) begin
              w_discard = 1'b1;
            end else begin
              w_store  = 1'b1;
              w_commit = 1'b1;
            end
          end else if (r_pkt_len == LEN_MAX) begin
            w_overflow   = 1'b1;
            w_next_state = S_SINK;
          end else begin
            w_store    = 1'b1;
            w_mark_set = w_ctrl_drop;
            if (!w_ctrl_other) begin
              w_next_state = S_BODY;
            end
          end
        end
        S_SINK: begin
          if (w_ctrl_other) begin
            w_sink_exit  = 1'b1;
            w_next_state = S_HDR;
          end
        end
        default: begin
          w_next_state = S_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {in_ctrl, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_HDR;
      r_mark         <= 1'b0;
      r_wr_ptr       <= '0;
      r_pkt_start    <= '0;
      r_commit_ptr   <= '0;
      r_pkt_len      <= '0;
      r_pass_cnt     <= '0;
      r_drop_cnt     <= '0;
      r_oversize_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + ONE_P;
      end
      if (w_discard || w_overflow) begin
        r_wr_ptr <= r_pkt_start;
      end
      if (w_commit) begin
        r_commit_ptr <= r_wr_ptr + ONE_P;
        r_pkt_start  <= r_wr_ptr + ONE_P;
        r_pass_cnt   <= r_pass_cnt + 32'd1;
      end
      if (w_discard) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
      if (w_sink_exit) begin
        r_oversize_cnt <= r_oversize_cnt + 32'd1;
      end
      if (w_discard || w_sink_exit) begin
        r_mark <= 1'b0;
      end else if (w_mark_set) begin
        r_mark <= 1'b1;
      end
      if (w_commit || w_discard || w_sink_exit) begin
        r_pkt_len <= '0;
      end else if (w_store) begin
        r_pkt_len <= r_pkt_len + ONE_P;
      end
    end
  end

  // The read side sees the commit pointer one cycle late, keeping the commit path off the RAM read.
  assign w_rd = (r_rd_ptr != r_rd_limit) && out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_limit <= '0;
      r_rd_ptr   <= '0;
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_ctrl <= '0;
    end else begin
      r_rd_limit <= r_commit_ptr;
      r_out_wr   <= w_rd;
      if (w_rd) begin
        r_rd_ptr                 <= r_rd_ptr + ONE_P;
        {r_out_ctrl, r_out_data} <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign out_data     = r_out_data;
  assign out_ctrl     = r_out_ctrl;
  assign out_wr       = r_out_wr;
  assign pass_cnt     = r_pass_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign oversize_cnt = r_oversize_cnt;

endmodule

// File: tb/tb_fw_drop_filter.sv
// tb/tb_fw_drop_filter.sv - randomized and directed checks of fw_drop_filter against a packet-level model
module tb_fw_drop_filter;

  localparam int DEPTH = 16;
  localparam logic [7:0] DROP = 8'h54;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic [31:0] pass_cnt, drop_cnt, oversize_cnt;

  fw_drop_filter #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(4), .DROP_CTRL(8'h54)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .oversize_cnt(oversize_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_pass = 0, m_drop = 0, m_over = 0;
  logic [71:0] exp_q[$];
  logic [71:0] pkt[$];
  logic [71:0] mon_e;
  int edge_cnt = 0;
  int eop_edge = 0;
  int first_out_edge = -1;
  int n_out = 0;
  int rdy_mode = 1;
  int rdy_phase = 0;
  logic rdy_q = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired before the awaited event", name);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  endtask

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rdy_q    <= out_rdy;
  end

  always @(posedge clk) begin
    if (!reset && in_wr && !in_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL illegal_write: in_wr=1 while in_rdy=0");
    end
  end

  // out_rdy patterns: 0 held low, 1 held high, 2 toggles every 3 cycles, 3 random
  always @(negedge clk) begin
    rdy_phase++;
    case (rdy_mode)
      0: out_rdy = 1'b0;
      1: out_rdy = 1'b1;
      2: if (rdy_phase % 3 == 0) out_rdy = ~out_rdy;
      default: out_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (out_wr) begin
      n_out++;
      if (first_out_edge < 0) first_out_edge = edge_cnt;
      chk("out_wr_needs_prior_rdy", rdy_q, 1'b1);
      chk("marker_on_out_ctrl", (out_ctrl == DROP), 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_out_word", {out_ctrl, out_data}, 72'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_word", {out_ctrl, out_data}, mon_e);
      end
    end
    chk("pass_cnt", pass_cnt, 32'(m_pass));
    chk("drop_cnt", drop_cnt, 32'(m_drop));
    chk("oversize_cnt", oversize_cnt, 32'(m_over));
  end

  function automatic logic [7:0] rand_ctrl();
    logic [7:0] c;
    c = 8'($urandom_range(1, 255));
    if (c == DROP) c = 8'h55;
    return c;
  endfunction

  task automatic add(input logic [7:0] c);
    pkt.push_back({c, $urandom, $urandom});
  endtask

  task automatic build_rand();
    int h, b;
    h = $urandom_range(0, 2);
    b = ($urandom_range(0, 9) < 2) ? $urandom_range(13, 20) : $urandom_range(1, 12);
    pkt.delete();
    for (int i = 0; i < h; i++) add(rand_ctrl());
    for (int i = 0; i < b; i++) add(($urandom_range(0, 15) == 0) ? DROP : 8'h00);
    add(rand_ctrl());
  endtask

  // Fate is decided per packet: too long -> oversize, any marked non-final word -> drop, else pass.
  task automatic send_pkt(input int gap_max, input bit expect_rdy, input int n_limit);
    int fate, n, waitc, g;
    fate = 0;
    n = (n_limit < 0) ? pkt.size() : n_limit;
    if (pkt.size() >= DEPTH) fate = 2;
    else for (int i = 0; i < pkt.size() - 1; i++) if (pkt[i][71:64] == DROP) fate = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (expect_rdy) chk("sink_in_rdy", in_rdy, 1'b1);
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
          in_wr = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      waitc = 0;
      while (!in_rdy) begin
        in_wr = 1'b0;
        if (waitc == 2000) abort("in_rdy_wait");
        @(negedge clk);
        waitc++;
      end
      in_wr   = 1'b1;
      in_ctrl = pkt[i][71:64];
      in_data = pkt[i][63:0];
      @(posedge clk);
      if (i == pkt.size() - 1) begin
        eop_edge = edge_cnt + 1;
        case (fate)
          0: begin
            foreach (pkt[j]) exp_q.push_back(pkt[j]);
            m_pass++;
          end
          1: m_drop++;
          default: m_over++;
        endcase
      end
    end
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0) begin
      if (c == 3000) abort("drain_wait");
      @(negedge clk);
      c++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_wr = 1'b0;
    @(posedge clk);
    exp_q.delete();
    m_pass = 0;
    m_drop = 0;
    m_over = 0;
    @(negedge clk);
    chk("rst_out_wr", out_wr, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_ctrl", out_ctrl, 8'h0);
    chk("rst_in_rdy", in_rdy, 1'b1);
    chk("rst_pass_cnt", pass_cnt, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    abort("global_timeout");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    do_reset();

    // clean packet: latency and order
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    pkt.delete();
    add(8'hFF); repeat (4) add(8'h00); add(8'h01);
    base = n_out;
    first_out_edge = -1;
    send_pkt(0, 1'b0, -1);
    drain();
    chk("t1_latency", 72'(first_out_edge - eop_edge), 72'd2);
    chk("t1_words_out", 72'(n_out - base), 72'd6);
    chk("t1_pass_lit", pass_cnt, 32'd1);
    chk("t1_model_pass", 72'(m_pass), 72'd1);

    // marked packet followed by clean one
    do_reset();
    pkt.delete();
    add(8'hFF); repeat (3) add(DROP); add(8'h80);
    base = n_out;
    send_pkt(0, 1'b0, -1);
    pkt.delete();
    add(8'hFF); add(8'h00); add(8'h00); add(8'h02);
    send_pkt(0, 1'b0, -1);
    drain();
    chk("t2_drop_lit", drop_cnt, 32'd1);
    chk("t2_pass_lit", pass_cnt, 32'd1);
    chk("t2_words_out", 72'(n_out - base), 72'd4);

    // clean, marked, clean with toggling out_rdy
    do_reset();
    rdy_mode = 2;
    base = n_out;
    for (int k = 0; k < 3; k++) begin
      pkt.delete();
      add(8'hFF);
      for (int i = 0; i < 8; i++) add((k == 1 && i == 4) ? DROP : 8'h00);
      add(8'h03);
      send_pkt(0, 1'b0, -1);
    end
    drain();
    chk("t3_words_out", 72'(n_out - base), 72'd20);
    chk("t3_pass_lit", pass_cnt, 32'd2);
    chk("t3_drop_lit", drop_cnt, 32'd1);

    // oversize boundaries: 20 and 16 words sink, 5 and 15 words pass
    do_reset();
    rdy_mode = 1;
    base = n_out;
    pkt.delete();
    add(8'hFF); repeat (18) add(8'h00); add(8'h01);
    send_pkt(0, 1'b1, -1);
    repeat (10) @(negedge clk);
    chk("t4_nothing_out", 72'(n_out - base), 72'd0);
    chk("t4_over_lit", oversize_cnt, 32'd1);
    pkt.delete();
    add(8'hFF); repeat (3) add(8'h00); add(8'h01);
    send_pkt(0, 1'b0, -1);
    drain();
    pkt.delete();
    add(8'hFF); repeat (13) add(8'h00); add(8'h01);
    send_pkt(0, 1'b0, -1);
    drain();
    pkt.delete();
    add(8'hFF); repeat (14) add(8'h00); add(8'h01);
    send_pkt(0, 1'b1, -1);
    drain();
    chk("t4_pass_lit", pass_cnt, 32'd2);
    chk("t4_over2_lit", oversize_cnt, 32'd2);
    chk("t4_words_out", 72'(n_out - base), 72'd20);

    // fill the buffer with out_rdy low, then release
    do_reset();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    base = n_out;
    for (int k = 0; k < 3; k++) begin
      pkt.delete();
      add(8'hFF); repeat (3) add(8'h00); add(8'h01);
      send_pkt(0, 1'b0, -1);
      if (k == 1) chk("t5_in_rdy_at_10", in_rdy, 1'b1);
    end
    chk("t5_in_rdy_at_15", in_rdy, 1'b0);
    chk("t5_nothing_out", 72'(n_out - base), 72'd0);
    rdy_mode = 1;
    pkt.delete();
    add(8'hFF); repeat (3) add(8'h00); add(8'h01);
    send_pkt(0, 1'b0, -1);
    drain();
    chk("t5_words_out", 72'(n_out - base), 72'd20);
    chk("t5_pass_lit", pass_cnt, 32'd4);

    // reset with a committed packet buffered and another partly written
    do_reset();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    pkt.delete();
    add(8'hFF); repeat (3) add(8'h00); add(8'h01);
    send_pkt(0, 1'b0, -1);
    pkt.delete();
    add(8'hFF); repeat (3) add(8'h00); add(8'h01);
    send_pkt(0, 1'b0, 3);
    do_reset();
    rdy_mode = 1;
    base = n_out;
    repeat (8) @(negedge clk);
    chk("t6_stale_out", 72'(n_out - base), 72'd0);
    pkt.delete();
    add(8'hFF); repeat (3) add(8'h00); add(8'h01);
    send_pkt(0, 1'b0, -1);
    drain();
    chk("t6_pass_lit", pass_cnt, 32'd1);
    chk("t6_words_out", 72'(n_out - base), 72'd5);

    // randomized traffic
    do_reset();
    rdy_mode = 3;
    for (int k = 0; k < 80; k++) begin
      build_rand();
      send_pkt(2, 1'b0, -1);
    end
    drain();
    chk("rand_queue_empty", 72'(exp_q.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
